roulette_round_ctrl: RTL and testbench

Sequences one roulette round around the 12-entry bet latch bank. Accepts decoded keyboard bet opcodes qualified by the chip-colour input and writes them into bet slots in order. On a spin command it locks betting, raises `spin_check` toward the register file until the wheel program reports completion, captures the winning number, then clears every slot before re-opening betting. It sits between the PS/2 keyboard-to-bet decoder and the bet registers/regfile in the top-level wrapper.

---
 rtl/roulette_round_ctrl_if.sv | 32 +++
 rtl/roulette_round_ctrl.sv | 167 ++++++++++++++++
 tb/tb_roulette_round_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/roulette_round_ctrl_if.sv
// Bus bundle for roulette_round_ctrl: keyboard bet input, wheel handshake, bet-slot write port and status.
// master = keyboard decoder / processor side, slave = round controller.
interface roulette_round_ctrl_if;
  logic       key_valid;
  logic [5:0] key_opcode;
  logic [2:0] chip_color;
  logic       spin_done;
  logic [5:0] result_number;
  logic       bet_wr_en;
  logic [3:0] bet_wr_idx;
  logic [7:0] bet_wr_data;
  logic [3:0] bet_count;
  logic       bets_full;
  logic       spin_check;
  logic       result_valid;
  logic [5:0] result_latched;
  logic       spin_timeout;
  logic       key_rejected;
  logic [2:0] state;

  modport master (
    output key_valid, key_opcode, chip_color, spin_done, result_number,
    input  bet_wr_en, bet_wr_idx, bet_wr_data, bet_count, bets_full, spin_check,
           result_valid, result_latched, spin_timeout, key_rejected, state
  );

  modport slave (
    input  key_valid, key_opcode, chip_color, spin_done, result_number,
    output bet_wr_en, bet_wr_idx, bet_wr_data, bet_count, bets_full, spin_check,
           result_valid, result_latched, spin_timeout, key_rejected, state
  );
endinterface

// File: rtl/roulette_round_ctrl.sv
// Roulette round sequencer: bet entry, spin handshake with timeout, result capture, slot clear.
// Optional ROULETTE_UNDO_EN: opcode 6'b111101 removes the most recent bet.
module roulette_round_ctrl #(
  parameter int unsigned MAX_BETS     = 12,
  parameter logic [23:0] SPIN_TIMEOUT = 24'd10_000_000
) (
  input logic                  clock,
  input logic                  reset,
  roulette_round_ctrl_if.slave bus
);

  localparam logic [5:0] OP_SPIN  = 6'b111110;
  localparam logic [5:0] OP_CLEAR = 6'b111111;
`ifdef ROULETTE_UNDO_EN
  localparam logic [5:0] OP_UNDO  = 6'b111101;
`endif
  localparam logic [3:0] FULL_CNT = 4'(MAX_BETS);
  localparam logic [3:0] LAST_IDX = 4'(MAX_BETS - 1);

  typedef enum logic [2:0] {
    BETTING  = 3'd0,
    SPINNING = 3'd1,
    RESULT   = 3'd2,
    CLEAR    = 3'd3
  } state_t;

  state_t      cur, nxt;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_idx_q, wr_idx_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [3:0]  count_q, count_d;
  logic        full_q, full_d;
  logic        spin_check_q, spin_check_d;
  logic        rvalid_q, rvalid_d;
  logic [5:0]  rlatched_q, rlatched_d;
  logic        timeout_q, timeout_d;
  logic        rejected_q, rejected_d;
  logic [23:0] tcnt_q, tcnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur          <= BETTING;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      spin_check_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rlatched_q   <= '0;
      timeout_q    <= 1'b0;
      rejected_q   <= 1'b0;
      tcnt_q       <= '0;
    end else begin
      cur          <= nxt;
      wr_en_q      <= wr_en_d;
      wr_idx_q     <= wr_idx_d;
      wr_data_q    <= wr_data_d;
      count_q      <= count_d;
      full_q       <= full_d;
      spin_check_q <= spin_check_d;
      rvalid_q     <= rvalid_d;
      rlatched_q   <= rlatched_d;
      timeout_q    <= timeout_d;
      rejected_q   <= rejected_d;
      tcnt_q       <= tcnt_d;
    end
  end

  // The clear write for slot 0 is issued on the edge that enters CLEAR, so the
  // MAX_BETS clear writes line up exactly with the MAX_BETS CLEAR cycles.
  always_comb begin
    nxt        = cur;
    wr_en_d    = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    rvalid_d   = 1'b0;
    rlatched_d = rlatched_q;
    timeout_d  = 1'b0;
    rejected_d = 1'b0;
    tcnt_d     = '0;
    unique case (cur)
      BETTING: begin
        if (bus.key_valid) begin
          if (bus.key_opcode == OP_SPIN) begin
            if (count_q != 4'd0) nxt = SPINNING;
            else                 rejected_d = 1'b1;
          end else if (bus.key_opcode == OP_CLEAR) begin
            nxt       = CLEAR;
            wr_en_d   = 1'b1;
            wr_idx_d  = '0;
            wr_data_d = '0;
`ifdef ROULETTE_UNDO_EN
          end else if (bus.key_opcode == OP_UNDO) begin
            if (count_q != 4'd0) begin
              wr_en_d   = 1'b1;
              wr_idx_d  = count_q - 4'd1;
              wr_data_d = '0;
              count_d   = count_q - 4'd1;
            end else begin
              rejected_d = 1'b1;
            end
`endif
          end else if (bus.chip_color != 3'b000 && count_q != FULL_CNT) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = count_q;
            wr_data_d = {bus.chip_color[1:0], bus.key_opcode};
            count_d   = count_q + 4'd1;
          end else begin
            rejected_d = 1'b1;
          end
        end
      end
      SPINNING: begin
        rejected_d = bus.key_valid;
        if (bus.spin_done) begin
          rlatched_d = bus.result_number;
          rvalid_d   = 1'b1;
          nxt        = RESULT;
        end else if (tcnt_q == SPIN_TIMEOUT - 24'd1) begin
          timeout_d = 1'b1;
          nxt       = CLEAR;
          wr_en_d   = 1'b1;
          wr_idx_d  = '0;
          wr_data_d = '0;
        end else begin
          tcnt_d = tcnt_q + 24'd1;
        end
      end
      RESULT: begin
        rejected_d = bus.key_valid;
        nxt        = CLEAR;
        wr_en_d    = 1'b1;
        wr_idx_d   = '0;
        wr_data_d  = '0;
      end
      CLEAR: begin
        rejected_d = bus.key_valid;
        if (wr_idx_q == LAST_IDX) begin
          nxt     = BETTING;
          count_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_idx_d  = wr_idx_q + 4'd1;
          wr_data_d = '0;
        end
      end
      default: nxt = BETTING;
    endcase
    spin_check_d = (nxt == SPINNING);
    full_d       = (count_d == FULL_CNT);
  end

  assign bus.bet_wr_en      = wr_en_q;
  assign bus.bet_wr_idx     = wr_idx_q;
  assign bus.bet_wr_data    = wr_data_q;
  assign bus.bet_count      = count_q;
  assign bus.bets_full      = full_q;
  assign bus.spin_check     = spin_check_q;
  assign bus.result_valid   = rvalid_q;
  assign bus.result_latched = rlatched_q;
  assign bus.spin_timeout   = timeout_q;
  assign bus.key_rejected   = rejected_q;
  assign bus.state          = cur;

endmodule

// File: tb/tb_roulette_round_ctrl.sv
// Directed self-checking bench for roulette_round_ctrl (MAX_BETS=12, SPIN_TIMEOUT=16).
module tb_roulette_round_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  roulette_round_ctrl_if bus ();

  roulette_round_ctrl #(
    .MAX_BETS     (12),
    .SPIN_TIMEOUT (24'd16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_key(input logic [5:0] op, input logic [2:0] col);
    bus.key_opcode = op;
    bus.chip_color = col;
    bus.key_valid  = 1'b1;
    tick();
    bus.key_valid  = 1'b0;
  endtask

  // Entered at the first CLEAR cycle; optionally pokes a bet key mid-clear.
  task automatic run_clear(input bit inject);
    for (int i = 0; i < 12; i++) begin
      check("clr_en", 32'(bus.bet_wr_en), 32'd1);
      check("clr_idx", 32'(bus.bet_wr_idx), 32'(i));
      check("clr_data", 32'(bus.bet_wr_data), 32'h00);
      check("clr_state", 32'(bus.state), 32'd3);
      if (inject && i == 5) check("clr_rej", 32'(bus.key_rejected), 32'd1);
      if (inject && i == 4) begin
        bus.key_opcode = 6'd5;
        bus.chip_color = 3'b001;
        bus.key_valid  = 1'b1;
      end
      tick();
      bus.key_valid = 1'b0;
    end
    check("clr_done_state", 32'(bus.state), 32'd0);
    check("clr_done_cnt", 32'(bus.bet_count), 32'd0);
    check("clr_done_full", 32'(bus.bets_full), 32'd0);
    check("clr_done_en", 32'(bus.bet_wr_en), 32'd0);
  endtask

  initial begin
    bus.key_valid     = 1'b0;
    bus.key_opcode    = '0;
    bus.chip_color    = '0;
    bus.spin_done     = 1'b0;
    bus.result_number = '0;
    tick();
    tick();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_cnt", 32'(bus.bet_count), 32'd0);
    check("rst_full", 32'(bus.bets_full), 32'd0);
    check("rst_spin", 32'(bus.spin_check), 32'd0);
    check("rst_res", 32'(bus.result_latched), 32'd0);
    check("rst_idx", 32'(bus.bet_wr_idx), 32'd0);
    check("rst_data", 32'(bus.bet_wr_data), 32'd0);
    check("rst_en", 32'(bus.bet_wr_en), 32'd0);
    check("rst_rej", 32'(bus.key_rejected), 32'd0);
    reset = 1'b1;
    tick();

    // three bets, opcode 5 colour 1 -> data 8'h45
    for (int i = 0; i < 3; i++) begin
      send_key(6'd5, 3'b001);
      check("bet_en", 32'(bus.bet_wr_en), 32'd1);
      check("bet_idx", 32'(bus.bet_wr_idx), 32'(i));
      check("bet_data", 32'(bus.bet_wr_data), 32'h45);
      check("bet_cnt", 32'(bus.bet_count), 32'(i + 1));
    end
    tick();
    check("bet_en_drop", 32'(bus.bet_wr_en), 32'd0);

    // clear-all with a key poked mid-clear
    send_key(6'b111111, 3'b000);
    run_clear(1'b1);

    // colour 0 and spin with no bets are rejected
    send_key(6'd5, 3'b000);
    check("col0_rej", 32'(bus.key_rejected), 32'd1);
    check("col0_en", 32'(bus.bet_wr_en), 32'd0);
    check("col0_cnt", 32'(bus.bet_count), 32'd0);
    send_key(6'b111110, 3'b001);
    check("spin0_rej", 32'(bus.key_rejected), 32'd1);
    check("spin0_state", 32'(bus.state), 32'd0);

    // 13 bets with colour 2 -> 12 writes then a reject
    for (int i = 0; i < 13; i++) begin
      send_key(6'(i), 3'b010);
      if (i < 12) begin
        check("fill_en", 32'(bus.bet_wr_en), 32'd1);
        check("fill_idx", 32'(bus.bet_wr_idx), 32'(i));
        check("fill_data", 32'(bus.bet_wr_data), 32'(8'h80 | i));
        check("fill_cnt", 32'(bus.bet_count), 32'(i + 1));
        check("fill_full", 32'(bus.bets_full), (i == 11) ? 32'd1 : 32'd0);
        check("fill_rej", 32'(bus.key_rejected), 32'd0);
      end else begin
        check("over_en", 32'(bus.bet_wr_en), 32'd0);
        check("over_rej", 32'(bus.key_rejected), 32'd1);
        check("over_cnt", 32'(bus.bet_count), 32'd12);
        check("over_full", 32'(bus.bets_full), 32'd1);
      end
    end
    send_key(6'b111111, 3'b000);
    run_clear(1'b0);

    // normal spin with result 17
    send_key(6'd9, 3'b011);
    send_key(6'b111110, 3'b000);
    check("spin_state", 32'(bus.state), 32'd1);
    check("spin_chk", 32'(bus.spin_check), 32'd1);
    send_key(6'd7, 3'b001);
    check("spin_rej", 32'(bus.key_rejected), 32'd1);
    check("spin_noen", 32'(bus.bet_wr_en), 32'd0);
    check("spin_cnt", 32'(bus.bet_count), 32'd1);
    bus.spin_done     = 1'b1;
    bus.result_number = 6'd17;
    tick();
    bus.spin_done     = 1'b0;
    check("res_state", 32'(bus.state), 32'd2);
    check("res_valid", 32'(bus.result_valid), 32'd1);
    check("res_num", 32'(bus.result_latched), 32'd17);
    check("res_spin_off", 32'(bus.spin_check), 32'd0);
    tick();
    check("res_valid_drop", 32'(bus.result_valid), 32'd0);
    run_clear(1'b0);
    check("res_hold", 32'(bus.result_latched), 32'd17);

    // spin_done outside SPINNING is ignored
    bus.spin_done     = 1'b1;
    bus.result_number = 6'd9;
    tick();
    bus.spin_done     = 1'b0;
    check("idle_done_valid", 32'(bus.result_valid), 32'd0);
    check("idle_done_res", 32'(bus.result_latched), 32'd17);
    check("idle_done_state", 32'(bus.state), 32'd0);

    // timeout: pulse 16 cycles after entering SPINNING
    send_key(6'd3, 3'b001);
    send_key(6'b111110, 3'b000);
    check("to_entry", 32'(bus.state), 32'd1);
    for (int k = 1; k < 16; k++) begin
      tick();
      check("to_hold_state", 32'(bus.state), 32'd1);
      check("to_hold_pulse", 32'(bus.spin_timeout), 32'd0);
    end
    tick();
    check("to_pulse", 32'(bus.spin_timeout), 32'd1);
    check("to_state", 32'(bus.state), 32'd3);
    check("to_spin_off", 32'(bus.spin_check), 32'd0);
    check("to_valid", 32'(bus.result_valid), 32'd0);
    run_clear(1'b0);
    check("to_res_hold", 32'(bus.result_latched), 32'd17);
    check("to_pulse_drop", 32'(bus.spin_timeout), 32'd0);

    // asynchronous reset in the middle of CLEAR
    send_key(6'd5, 3'b001);
    send_key(6'b111111, 3'b000);
    tick();
    tick();
    check("mid_clr_idx", 32'(bus.bet_wr_idx), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("arst_state", 32'(bus.state), 32'd0);
    check("arst_en", 32'(bus.bet_wr_en), 32'd0);
    check("arst_idx", 32'(bus.bet_wr_idx), 32'd0);
    check("arst_cnt", 32'(bus.bet_count), 32'd0);
    check("arst_res", 32'(bus.result_latched), 32'd0);
    tick();
    reset = 1'b1;
    tick();

`ifdef ROULETTE_UNDO_EN
    send_key(6'd5, 3'b001);
    send_key(6'd6, 3'b001);
    send_key(6'b111101, 3'b001);
    check("undo_en", 32'(bus.bet_wr_en), 32'd1);
    check("undo_idx", 32'(bus.bet_wr_idx), 32'd1);
    check("undo_data", 32'(bus.bet_wr_data), 32'h00);
    check("undo_cnt", 32'(bus.bet_count), 32'd1);
    send_key(6'b111101, 3'b001);
    check("undo2_idx", 32'(bus.bet_wr_idx), 32'd0);
    check("undo2_cnt", 32'(bus.bet_count), 32'd0);
    send_key(6'b111101, 3'b001);
    check("undo0_rej", 32'(bus.key_rejected), 32'd1);
    check("undo0_en", 32'(bus.bet_wr_en), 32'd0);
`else
    send_key(6'b111101, 3'b001);
    check("op3d_en", 32'(bus.bet_wr_en), 32'd1);
    check("op3d_idx", 32'(bus.bet_wr_idx), 32'd0);
    check("op3d_data", 32'(bus.bet_wr_data), 32'h7D);
    check("op3d_cnt", 32'(bus.bet_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
